// File: rtl/fifo_stream_reader.sv
// Read-side master for sync_fifo: hides the 1-cycle FIFO read latency behind a 2-entry buffer
// and presents the words as a valid/ready stream. Optional m_tlast framing: define FIFO_RD_TLAST_EN.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
`ifdef FIFO_RD_TLAST_EN
    output logic                  m_tlast,
`endif
    output logic [15:0]           xfer_count
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CREDIT_W = 3;

    if (PKT_LEN == 0) begin : g_pkt_len_chk
        $error("fifo_stream_reader: PKT_LEN must be >= 1");
    end

    // State encoding doubles as the buffer occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    inflight_q;
    logic [DATA_WIDTH-1:0]   skid_q;
    logic                    pop;
    logic                    capture;
    logic                    load_out;
    logic                    load_skid;
    logic                    out_from_skid;
    logic [CREDIT_W-1:0]     credit;

    assign pop     = m_tvalid & m_tready;
    assign capture = inflight_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic on buffer occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (capture) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (capture && !pop) begin
                    state_d = ST_FULL;
                end else if (pop && !capture) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Buffer write steering and read credit; a capture while FULL is excluded by the credit rule.
    always_comb begin
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: load_out = capture;
            ST_ONE: begin
                if (capture && pop) begin
                    load_out = 1'b1;
                end else if (capture) begin
                    load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: ;
        endcase
        credit    = CREDIT_W'(state_q) + CREDIT_W'(inflight_q) - CREDIT_W'(pop);
        fifo_r_en = rst & ~fifo_empty & (credit < CREDIT_W'(2));
    end

    // Datapath and stream outputs; a word in flight at reset is dropped with inflight_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            skid_q     <= '0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight_q <= fifo_r_en;
            if (load_skid) begin
                skid_q <= fifo_data;
            end
            if (load_out) begin
                m_tdata <= out_from_skid ? skid_q : fifo_data;
            end
            m_tvalid <= (state_d != ST_EMPTY);
            if (pop) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

`ifdef FIFO_RD_TLAST_EN
    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    // Beat position within the packet; m_tlast tracks the beat now on the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q  <= '0;
            m_tlast <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            m_tlast <= (state_d != ST_EMPTY) && (beat_d == BEAT_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomised-ready bench for fifo_stream_reader with a behavioural sync_fifo read port.
module tb_fifo_stream_reader;

    localparam int unsigned DW    = 8;
    localparam int unsigned PKT   = 4;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_r_en;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [15:0]   xfer_count;
`ifdef FIFO_RD_TLAST_EN
    logic          m_tlast;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
`ifdef FIFO_RD_TLAST_EN
        .m_tlast    (m_tlast),
`endif
        .xfer_count (xfer_count)
    );

    // Behavioural FIFO: registered data_out one cycle after an accepted read.
    logic [DW-1:0] mem [0:DEPTH-1];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          flush_req = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_r_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr[11:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Stream monitor: scoreboard order, hold-under-stall, no read while empty, framing.
    int            exp_idx  = 0;
    int            sb_err   = 0;
    int            stab_err = 0;
    int            ren_err  = 0;
    int            tl_err   = 0;
    int            mon_beat = 0;
    logic          stall_q  = 1'b0;
    logic [DW-1:0] hold_data = '0;

    always @(negedge clk) begin
        if (flush_req) begin
            exp_idx <= wr_ptr;
        end
        if (!rst) begin
            stall_q  <= 1'b0;
            mon_beat <= 0;
        end else begin
            if (fifo_r_en && fifo_empty) begin
                ren_err <= ren_err + 1;
            end
            if (stall_q && (!m_tvalid || (m_tdata !== hold_data))) begin
                stab_err <= stab_err + 1;
            end
            stall_q   <= m_tvalid && !m_tready;
            hold_data <= m_tdata;
`ifdef FIFO_RD_TLAST_EN
            if (m_tlast !== (m_tvalid && (mon_beat == int'(PKT) - 1))) begin
                tl_err <= tl_err + 1;
            end
`endif
            if (m_tvalid && m_tready) begin
                if ((exp_idx == wr_ptr) || (m_tdata !== mem[exp_idx[11:0]])) begin
                    sb_err <= sb_err + 1;
                end
                exp_idx  <= exp_idx + 1;
                mon_beat <= (mon_beat == int'(PKT) - 1) ? 0 : mon_beat + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr[11:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic rst_pulse();
        rst       = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input logic rand_ready);
        int k;
        k = 0;
        while (((exp_idx != wr_ptr) || m_tvalid) && (k < 4000)) begin
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        if (k >= 4000) begin
            check(tag, 32'(k), 32'(0));
        end
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        m_tready = 1'b1;

        // T1: held in reset with data waiting, then reset asserted mid-burst.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (3) tick();
        check("t1_ren_in_reset", 32'(fifo_r_en), 32'(0));
        check("t1_valid_in_reset", 32'(m_tvalid), 32'(0));
        check("t1_xfer_in_reset", 32'(xfer_count), 32'(0));
        check("t1_data_in_reset", 32'(m_tdata), 32'(0));
        rst = 1'b1;
        #1;
        check("t1_ren_release", 32'(fifo_r_en), 32'(1));
        repeat (3) tick();
        check("t1_burst_xfer", 32'(xfer_count), 32'(1));
        check("t1_burst_data", 32'(m_tdata), 32'h22);
        rst       = 1'b0;
        flush_req = 1'b1;
        #1;
        check("t1_async_valid", 32'(m_tvalid), 32'(0));
        check("t1_async_data", 32'(m_tdata), 32'(0));
        check("t1_async_xfer", 32'(xfer_count), 32'(0));
        check("t1_async_ren", 32'(fifo_r_en), 32'(0));
        tick();
        flush_req = 1'b0;
        tick();
        rst = 1'b1;

        // T2: single word latency.
        tick();
        push(8'hA5);
        #1;
        check("t2_ren_cycle_n", 32'(fifo_r_en), 32'(1));
        tick();
        check("t2_valid_n1", 32'(m_tvalid), 32'(0));
        check("t2_ren_n1", 32'(fifo_r_en), 32'(0));
        tick();
        check("t2_valid_n2", 32'(m_tvalid), 32'(1));
        check("t2_data_n2", 32'(m_tdata), 32'hA5);
        tick();
        check("t2_valid_after", 32'(m_tvalid), 32'(0));
        check("t2_ren_after", 32'(fifo_r_en), 32'(0));
        check("t2_xfer", 32'(xfer_count), 32'(1));

        // T3: back-to-back throughput.
        rst_pulse();
        for (int i = 1; i <= 6; i++) begin
            push(DW'(i));
        end
        tick();
        check("t3_valid_pre", 32'(m_tvalid), 32'(0));
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t3_valid", 32'(m_tvalid), 32'(1));
            check("t3_data", 32'(m_tdata), 32'(i));
        end
        tick();
        check("t3_valid_end", 32'(m_tvalid), 32'(0));
        check("t3_xfer", 32'(xfer_count), 32'(6));

        // T4: backpressure fills both entries, then releases in order.
        rst_pulse();
        m_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(DW'(8'hB0 + i));
        end
        repeat (10) tick();
        check("t4_stall_valid", 32'(m_tvalid), 32'(1));
        check("t4_stall_data", 32'(m_tdata), 32'hB1);
        check("t4_stall_ren", 32'(fifo_r_en), 32'(0));
        check("t4_stall_fifo_left", 32'(wr_ptr - rd_ptr), 32'(2));
        m_tready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t4_valid", 32'(m_tvalid), 32'(1));
            check("t4_data", 32'(m_tdata), 32'(8'hB0 + i));
        end
        tick();
        check("t4_valid_end", 32'(m_tvalid), 32'(0));
        check("t4_xfer", 32'(xfer_count), 32'(4));

        // T5: random ready with bursty refills and empty gaps.
        rst_pulse();
        begin
            int pushed;
            int cyc;
            pushed = 0;
            cyc    = 0;
            while ((pushed < 1000) && (cyc < 20000)) begin
                m_tready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) begin
                    int n;
                    n = int'($urandom_range(1, 4));
                    for (int j = 0; (j < n) && (pushed < 1000); j++) begin
                        push(DW'($urandom));
                        pushed++;
                    end
                end
                tick();
                cyc++;
            end
            check("t5_pushed", 32'(pushed), 32'(1000));
        end
        drain("t5_drain_timeout", 1'b1);
        check("t5_xfer", 32'(xfer_count), 32'(1000));
        m_tready = 1'b1;

`ifdef FIFO_RD_TLAST_EN
        // T6: packet framing and counter wrap.
        rst_pulse();
        for (int i = 0; i < 8; i++) begin
            push(DW'(8'hC0 + i));
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_valid", 32'(m_tvalid), 32'(1));
            check("t6_tlast", 32'(m_tlast), 32'((i % 4) == 3));
        end
        tick();
        check("t6_tlast_idle", 32'(m_tlast), 32'(0));
        for (int i = 8; i < 65535; i++) begin
            push(DW'(i));
            tick();
        end
        drain("t6_drain_timeout", 1'b0);
        check("t6_xfer_max", 32'(xfer_count), 32'hFFFF);
        push(8'h5A);
        repeat (4) tick();
        check("t6_xfer_wrap", 32'(xfer_count), 32'(0));
        check("t6_tlast_errors", 32'(tl_err), 32'(0));
`endif

        check("sb_data_errors", 32'(sb_err), 32'(0));
        check("sb_all_delivered", 32'(exp_idx), 32'(wr_ptr));
        check("stall_hold_errors", 32'(stab_err), 32'(0));
        check("ren_while_empty", 32'(ren_err), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
